// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-style execute pipeline.
//   - exe_cmd encodings for the ALU (EXE_MOV .. EXE_EOR)
//   - NZCV bit positions inside the 4-bit status word
//   - default datapath / register-index widths
package arm_pkg;

  localparam int unsigned ARM_DW = 32;
  localparam int unsigned ARM_RW = 4;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Flag-update masks in NZCV order.
  localparam logic [3:0] MASK_ALL   = 4'b1111;
  localparam logic [3:0] MASK_NZ    = 4'b1100;
  localparam logic [3:0] MASK_NONE  = 4'b0000;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU for the execute stage.
// Ports:
//   val1, val2  - operands (Rn, generated Val2)
//   exe_cmd     - ALU command (arm_pkg EXE_*)
//   c_in        - registered carry flag, used by ADC/SBC
//   result      - ALU result
//   nzcv_next   - candidate NZCV flags
//   flag_mask   - which NZCV bits the command is allowed to update
module alu_core
  import arm_pkg::*;
#(
  parameter int unsigned DW = ARM_DW
) (
  input  logic [DW-1:0] val1,
  input  logic [DW-1:0] val2,
  input  logic [3:0]    exe_cmd,
  input  logic          c_in,
  output logic [DW-1:0] result,
  output logic [3:0]    nzcv_next,
  output logic [3:0]    flag_mask
);

  logic [DW:0] sum;
  logic        is_add;
  logic        is_sub;

  always_comb begin
    sum       = '0;
    result    = '0;
    is_add    = 1'b0;
    is_sub    = 1'b0;
    flag_mask = MASK_NONE;
    unique case (exe_cmd)
      EXE_MOV: begin result = val2;         flag_mask = MASK_NZ; end
      EXE_MVN: begin result = ~val2;        flag_mask = MASK_NZ; end
      EXE_AND: begin result = val1 & val2;  flag_mask = MASK_NZ; end
      EXE_ORR: begin result = val1 | val2;  flag_mask = MASK_NZ; end
      EXE_EOR: begin result = val1 ^ val2;  flag_mask = MASK_NZ; end
      EXE_ADD, EXE_ADC: begin
        sum       = {1'b0, val1} + {1'b0, val2} +
                    {{DW{1'b0}}, (exe_cmd == EXE_ADC) & c_in};
        result    = sum[DW-1:0];
        is_add    = 1'b1;
        flag_mask = MASK_ALL;
      end
      EXE_SUB, EXE_SBC: begin
        // a + ~b + 1 (or + C for SBC): the carry out is directly NOT borrow.
        sum       = {1'b0, val1} + {1'b0, ~val2} +
                    {{DW{1'b0}}, (exe_cmd == EXE_SBC) ? c_in : 1'b1};
        result    = sum[DW-1:0];
        is_sub    = 1'b1;
        flag_mask = MASK_ALL;
      end
      default: ;
    endcase

    nzcv_next         = '0;
    nzcv_next[FLAG_N] = result[DW-1];
    nzcv_next[FLAG_Z] = (result == '0);
    nzcv_next[FLAG_C] = sum[DW];
    nzcv_next[FLAG_V] = (is_add & (val1[DW-1] == val2[DW-1]) & (result[DW-1] != val1[DW-1])) |
                        (is_sub & (val1[DW-1] != val2[DW-1]) & (result[DW-1] != val1[DW-1]));
  end

endmodule

// File: rtl/exe_alu_stage.sv
// Execute stage: ALU, NZCV status register and EXE/MEM pipeline register.
// Inputs:  clk, rst_n (sync, active low), in_valid, freeze, flush, val1, val2,
//          exe_cmd, s_bit, wb_en, mem_r_en, mem_w_en, dest, st_val
// Outputs: out_valid, alu_res, out_wb_en, out_mem_r_en, out_mem_w_en,
//          out_dest, out_st_val, status (NZCV, N in bit 3). All registered.
module exe_alu_stage
  import arm_pkg::*;
#(
  parameter int unsigned DW = ARM_DW,
  parameter int unsigned RW = ARM_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          freeze,
  input  logic          flush,
  input  logic [DW-1:0] val1,
  input  logic [DW-1:0] val2,
  input  logic [3:0]    exe_cmd,
  input  logic          s_bit,
  input  logic          wb_en,
  input  logic          mem_r_en,
  input  logic          mem_w_en,
  input  logic [RW-1:0] dest,
  input  logic [DW-1:0] st_val,
  output logic          out_valid,
  output logic [DW-1:0] alu_res,
  output logic          out_wb_en,
  output logic          out_mem_r_en,
  output logic          out_mem_w_en,
  output logic [RW-1:0] out_dest,
  output logic [DW-1:0] out_st_val,
  output logic [3:0]    status
);

  logic          valid_q, valid_d;
  logic [DW-1:0] res_q, res_d;
  logic          wb_q, wb_d;
  logic          mr_q, mr_d;
  logic          mw_q, mw_d;
  logic [RW-1:0] dest_q, dest_d;
  logic [DW-1:0] st_q, st_d;
  logic [3:0]    status_q, status_d;

  logic [DW-1:0] alu_result;
  logic [3:0]    nzcv_next;
  logic [3:0]    flag_mask;

  alu_core #(
    .DW (DW)
  ) u_alu_core (
    .val1      (val1),
    .val2      (val2),
    .exe_cmd   (exe_cmd),
    .c_in      (status_q[FLAG_C]),
    .result    (alu_result),
    .nzcv_next (nzcv_next),
    .flag_mask (flag_mask)
  );

  always_comb begin
    valid_d  = valid_q;
    res_d    = res_q;
    wb_d     = wb_q;
    mr_d     = mr_q;
    mw_d     = mw_q;
    dest_d   = dest_q;
    st_d     = st_q;
    status_d = status_q;
    if (flush || (!freeze && !in_valid)) begin
      // Bubble: everything cleared, flags untouched.
      valid_d = 1'b0;
      res_d   = '0;
      wb_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      dest_d  = '0;
      st_d    = '0;
    end else if (!freeze) begin
      valid_d = 1'b1;
      res_d   = alu_result;
      wb_d    = wb_en;
      mr_d    = mem_r_en;
      mw_d    = mem_w_en;
      dest_d  = dest;
      st_d    = st_val;
      if (s_bit) begin
        status_d = (status_q & ~flag_mask) | (nzcv_next & flag_mask);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      res_q    <= '0;
      wb_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      dest_q   <= '0;
      st_q     <= '0;
      status_q <= '0;
    end else begin
      valid_q  <= valid_d;
      res_q    <= res_d;
      wb_q     <= wb_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      dest_q   <= dest_d;
      st_q     <= st_d;
      status_q <= status_d;
    end
  end

  assign out_valid    = valid_q;
  assign alu_res      = res_q;
  assign out_wb_en    = wb_q;
  assign out_mem_r_en = mr_q;
  assign out_mem_w_en = mw_q;
  assign out_dest     = dest_q;
  assign out_st_val   = st_q;
  assign status       = status_q;

endmodule

// File: tb/tb_exe_alu_stage.sv
module tb_exe_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, freeze, flush;
  logic [31:0] val1, val2, st_val;
  logic [3:0]  exe_cmd;
  logic        s_bit, wb_en, mem_r_en, mem_w_en;
  logic [3:0]  dest;
  logic        out_valid;
  logic [31:0] alu_res, out_st_val;
  logic        out_wb_en, out_mem_r_en, out_mem_w_en;
  logic [3:0]  out_dest;
  logic [3:0]  status;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  exe_alu_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .freeze       (freeze),
    .flush        (flush),
    .val1         (val1),
    .val2         (val2),
    .exe_cmd      (exe_cmd),
    .s_bit        (s_bit),
    .wb_en        (wb_en),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .dest         (dest),
    .st_val       (st_val),
    .out_valid    (out_valid),
    .alu_res      (alu_res),
    .out_wb_en    (out_wb_en),
    .out_mem_r_en (out_mem_r_en),
    .out_mem_w_en (out_mem_w_en),
    .out_dest     (out_dest),
    .out_st_val   (out_st_val),
    .status       (status)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one valid instruction (no stall) and advance one edge.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic s);
    in_valid = 1'b1; freeze = 1'b0; flush = 1'b0;
    exe_cmd = cmd; val1 = a; val2 = b; s_bit = s;
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; freeze = 1'b0; flush = 1'b0;
    s_bit = 1'b1; wb_en = 1'b1; mem_r_en = 1'b1; mem_w_en = 1'b1;
    dest = 4'hF; st_val = $urandom; val1 = $urandom; val2 = $urandom; exe_cmd = 4'b0010;
    tick();
    val1 = $urandom; val2 = $urandom; st_val = $urandom;
    tick();
    check_eq("rst_valid",  {31'b0, out_valid}, 32'd0);
    check_eq("rst_res",    alu_res, 32'd0);
    check_eq("rst_ctrl",   {29'b0, out_wb_en, out_mem_r_en, out_mem_w_en}, 32'd0);
    check_eq("rst_dest",   {28'b0, out_dest}, 32'd0);
    check_eq("rst_st",     out_st_val, 32'd0);
    check_eq("rst_status", {28'b0, status}, 32'd0);

    // Release with nothing in flight.
    rst_n = 1'b1; in_valid = 1'b0; wb_en = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    dest = 4'd0; st_val = 32'd0;
    tick();
    check_eq("idle_valid",  {31'b0, out_valid}, 32'd0);
    check_eq("idle_status", {28'b0, status}, 32'd0);

    // ADDS signed overflow.
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1);
    check_eq("adds_ovf_res", alu_res, 32'h8000_0000);
    check_eq("adds_ovf_nzcv", {28'b0, status}, 32'b1001);
    check_eq("adds_ovf_valid", {31'b0, out_valid}, 32'd1);

    // SUBS 5-5 then SBC 10-3 with C=1.
    issue(4'b0100, 32'd5, 32'd5, 1'b1);
    check_eq("subs_res", alu_res, 32'd0);
    check_eq("subs_nzcv", {28'b0, status}, 32'b0110);
    issue(4'b0101, 32'd10, 32'd3, 1'b0);
    check_eq("sbc_c1_res", alu_res, 32'd7);
    check_eq("sbc_nos_nzcv", {28'b0, status}, 32'b0110);

    // SUBS with borrow, then SBCS consumes C=0.
    issue(4'b0100, 32'd3, 32'd5, 1'b1);
    check_eq("subs_borrow_res", alu_res, 32'hFFFF_FFFE);
    check_eq("subs_borrow_nzcv", {28'b0, status}, 32'b1000);
    issue(4'b0101, 32'd10, 32'd3, 1'b1);
    check_eq("sbcs_c0_res", alu_res, 32'd6);
    check_eq("sbcs_c0_nzcv", {28'b0, status}, 32'b0010);

    // Logical ops keep C/V.
    issue(4'b0010, 32'hFFFF_FFFF, 32'h1, 1'b1);
    check_eq("adds_wrap_res", alu_res, 32'd0);
    check_eq("adds_wrap_nzcv", {28'b0, status}, 32'b0110);
    issue(4'b0110, 32'hF0, 32'h0F, 1'b1);
    check_eq("ands_res", alu_res, 32'd0);
    check_eq("ands_nzcv", {28'b0, status}, 32'b0110);
    issue(4'b0111, 32'h8000_0000, 32'h0, 1'b1);
    check_eq("orrs_res", alu_res, 32'h8000_0000);
    check_eq("orrs_nzcv", {28'b0, status}, 32'b1010);

    // ADCS uses registered C=1: 2+3+1.
    issue(4'b0011, 32'd2, 32'd3, 1'b1);
    check_eq("adcs_res", alu_res, 32'd6);
    check_eq("adcs_nzcv", {28'b0, status}, 32'b0000);

    // EOR / MVN.
    issue(4'b1000, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
    check_eq("eor_res", alu_res, 32'hF0F0_F0F0);
    issue(4'b1001, 32'd0, 32'hFFFF_FFFF, 1'b1);
    check_eq("mvns_res", alu_res, 32'd0);
    check_eq("mvns_nzcv", {28'b0, status}, 32'b0100);

    // Undefined command: result 0, flags unchanged.
    issue(4'b0000, 32'd1, 32'd1, 1'b1);
    check_eq("undef_res", alu_res, 32'd0);
    check_eq("undef_nzcv", {28'b0, status}, 32'b0100);

    // Load a known entry, then freeze for 3 cycles.
    wb_en = 1'b1; dest = 4'd7; st_val = 32'hAA;
    issue(4'b0001, 32'd0, 32'h8000_0055, 1'b1);
    check_eq("movs_res", alu_res, 32'h8000_0055);
    check_eq("movs_nzcv", {28'b0, status}, 32'b1000);
    freeze = 1'b1; exe_cmd = 4'b0010; val1 = 32'd0; val2 = 32'd0; s_bit = 1'b1;
    wb_en = 1'b0; dest = 4'd2; st_val = 32'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("frz_res", alu_res, 32'h8000_0055);
      check_eq("frz_dest", {28'b0, out_dest}, 32'd7);
      check_eq("frz_st", out_st_val, 32'hAA);
      check_eq("frz_wb", {31'b0, out_wb_en}, 32'd1);
      check_eq("frz_nzcv", {28'b0, status}, 32'b1000);
    end

    // Flush beats freeze: bubble, status unchanged (ADDS 0+0 would set Z).
    flush = 1'b1; wb_en = 1'b1; mem_w_en = 1'b1;
    tick();
    check_eq("flush_valid", {31'b0, out_valid}, 32'd0);
    check_eq("flush_ctrl", {29'b0, out_wb_en, out_mem_r_en, out_mem_w_en}, 32'd0);
    check_eq("flush_res", alu_res, 32'd0);
    check_eq("flush_nzcv", {28'b0, status}, 32'b1000);
    flush = 1'b0; freeze = 1'b0; mem_w_en = 1'b0;

    // LDR address: controls pass through, status unchanged.
    wb_en = 1'b1; mem_r_en = 1'b1; dest = 4'd4; st_val = 32'h1234;
    issue(4'b0010, 32'h100, 32'h8, 1'b0);
    check_eq("ldr_res", alu_res, 32'h108);
    check_eq("ldr_ctrl", {29'b0, out_wb_en, out_mem_r_en, out_mem_w_en}, 32'b110);
    check_eq("ldr_dest", {28'b0, out_dest}, 32'd4);
    check_eq("ldr_st", out_st_val, 32'h1234);
    check_eq("ldr_nzcv", {28'b0, status}, 32'b1000);

    // in_valid low: bubble, flags unchanged even with s_bit set.
    in_valid = 1'b0; s_bit = 1'b1; val1 = 32'd0; val2 = 32'd0;
    tick();
    check_eq("bubble_valid", {31'b0, out_valid}, 32'd0);
    check_eq("bubble_res", alu_res, 32'd0);
    check_eq("bubble_dest", {28'b0, out_dest}, 32'd0);
    check_eq("bubble_nzcv", {28'b0, status}, 32'b1000);

    // Reset overrides freeze.
    rst_n = 1'b0; freeze = 1'b1; in_valid = 1'b1;
    tick();
    check_eq("rst_frz_nzcv", {28'b0, status}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
